// File: rtl/tc0_prescaler_pkg.sv
// rtl/tc0_prescaler_pkg.sv - shared TC0 clock-select encodings and GTCCR bit positions
//
// Purpose: common types for the TC0 prescaler, counter and output-compare blocks.
// Contents:
//   cs_e               clock-select (CS02:0) encoding
//   GTCCR_TSM_BIT      bit index of TSM in GTCCR
//   GTCCR_PSRSYNC_BIT  bit index of PSRSYNC in GTCCR
package tc0_pkg;

  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_DIV1     = 3'd1,
    CS_DIV8     = 3'd2,
    CS_DIV64    = 3'd3,
    CS_DIV256   = 3'd4,
    CS_DIV1024  = 3'd5,
    CS_EXT_FALL = 3'd6,
    CS_EXT_RISE = 3'd7
  } cs_e;

  localparam int GTCCR_TSM_BIT     = 7;
  localparam int GTCCR_PSRSYNC_BIT = 0;

endpackage

// File: rtl/tc0_prescaler_if.sv
// rtl/tc0_prescaler_if.sv - register bus bundle for the TC0 prescaler GTCCR access
//
// Purpose: groups the byte-wide register bus signals.
// Signals:
//   write  single-cycle write strobe
//   read   read strobe
//   addr   8-bit register address
//   wdata  8-bit write data
//   rdata  8-bit read data, 8'h00 when the slave is not selected (OR-muxable)
interface tc0_prescaler_if;

  logic       write;
  logic       read;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (
    output write,
    output read,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  write,
    input  read,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/tc0_prescaler_t0_edge_sync.sv
// rtl/tc0_prescaler_t0_edge_sync.sv - three-flop synchroniser and edge detector for the t0 pin
//
// Purpose: brings the asynchronous t0 pin into the clk domain and flags its edges.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   t0    asynchronous external clock pin
//   rise  high for one cycle after a synchronised 0->1 transition
//   fall  high for one cycle after a synchronised 1->0 transition
module t0_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic t0,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 are the metastability pair; s3 is the previous synchronised value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= t0;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/tc0_prescaler.sv
// rtl/tc0_prescaler.sv - TC0 clock-select, 10-bit prescaler and GTCCR register
//
// Purpose: produces the registered single-cycle count enable for the TC0 counter.
// Parameters:
//   GTCCR_ADDR  bus address of GTCCR
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   cs        clock select (CS02:0)
//   bus       register bus (slave side), GTCCR read/write
//   t0        asynchronous external clock pin, below f_clk/2
//   count_en  registered count-enable pulse
module tc0_prescaler
  import tc0_pkg::*;
#(
  parameter logic [7:0] GTCCR_ADDR = 8'h43
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cs,
  tc0_prescaler_if.slave   bus,
  input  logic             t0,
  output logic             count_en
);

  logic [9:0] presc;
  logic       tsm;
  logic       psrsync;
  logic       t0_rise;
  logic       t0_fall;
  logic       sel;
  logic       wr;
  logic       wr_tsm;
  logic       wr_psr;
  logic       tap8;
  logic       tap64;
  logic       tap256;
  logic       tap1024;
  logic       en_next;
  cs_e        cs_sel;
  logic       unused_wdata;

  assign sel    = (bus.addr == GTCCR_ADDR);
  assign wr     = bus.write & sel;
  assign wr_tsm = bus.wdata[GTCCR_TSM_BIT];
  assign wr_psr = bus.wdata[GTCCR_PSRSYNC_BIT];
  assign cs_sel = cs_e'(cs);

  assign unused_wdata = ^bus.wdata[6:1];

  t0_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .t0   (t0),
    .rise (t0_rise),
    .fall (t0_fall)
  );

  // A held PSRSYNC (TSM=1) pins the prescaler at zero; a PSRSYNC write
  // clears it at the write edge in place of the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= 10'd0;
    end else if (psrsync || (wr && wr_psr)) begin
      presc <= 10'd0;
    end else begin
      presc <= presc + 10'd1;
    end
  end

  // PSRSYNC can only stay set while TSM is being written 1; with TSM=0 it
  // never latches, so it acts as a one-shot prescaler reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tsm     <= 1'b0;
      psrsync <= 1'b0;
    end else if (wr) begin
      tsm <= wr_tsm;
      if (wr_psr) begin
        psrsync <= wr_tsm;
      end else begin
        psrsync <= psrsync & wr_tsm;
      end
    end
  end

  always_comb begin
    tap8    = (presc[2:0] == 3'd7);
    tap64   = (presc[5:0] == 6'd63);
    tap256  = (presc[7:0] == 8'd255);
    tap1024 = (presc == 10'd1023);
    en_next = 1'b0;
    case (cs_sel)
      CS_STOP:     en_next = 1'b0;
      CS_DIV1:     en_next = 1'b1;
      CS_DIV8:     en_next = tap8;
      CS_DIV64:    en_next = tap64;
      CS_DIV256:   en_next = tap256;
      CS_DIV1024:  en_next = tap1024;
      CS_EXT_FALL: en_next = t0_fall;
      CS_EXT_RISE: en_next = t0_rise;
      default:     en_next = 1'b0;
    endcase
  end

  // Uses the registered PSRSYNC, so a tap coinciding with a PSRSYNC write
  // still produces its pulse from the pre-write prescaler value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_en <= 1'b0;
    end else begin
      count_en <= en_next & ~psrsync;
    end
  end

  assign bus.rdata = (bus.read && sel) ? {tsm, 6'b000000, psrsync} : 8'h00;

endmodule
